lcd_video_rx: RTL
=================

// Module: lcd_video_rx
// PURPOSE
//  Receiving end of the LCD video timing interface (HD/VD/DEN/R/G/B) driven by
//  CARACTERES_LCD. Sits downstream of the LCD timing generator, clocked by NCLK.
//  Recovers per-pixel X/Y coordinates and checks line length and frame height
//  against expected values, with sticky error flags. Reports per-frame status;
//  used as an in-system monitor and as a self-checking bench component.
// PARAMETERS
//  H_ACTIVE  800  expected active (DEN=1) pixels per line
//  V_ACTIVE  480  expected active lines per frame
//  XW        11   width of PIX_X / pixel counters
//  YW        10   width of PIX_Y / line counters
// PORTS
//  CLK           in   1   pixel clock (connect to NCLK); all logic on rising edge
//  RST_n         in   1   asynchronous reset, active-low
//  HD            in   1   horizontal sync, active-low
//  VD            in   1   vertical sync, active-low
//  DEN           in   1   data enable, active-high
//  R, G, B       in   8   pixel colour, valid when DEN=1
//  CLR_ERR       in   1   synchronous clear of sticky error flags
//  PIX_VALID     out  1   registered pixel strobe
//  PIX_X         out  XW  column of current pixel (0-based)
//  PIX_Y         out  YW  row of current pixel (0-based)
//  PIX_RGB       out  24  {R,G,B} of current pixel
//  FRAME_DONE    out  1   one-cycle pulse at end of each checked frame
//  LINES_LAST    out  YW  active line count of the last completed frame
//  FRAME_CNT     out  16  completed frames, wraps 0xFFFF->0
//  LOCKED        out  1   last frame had correct geometry and no errors
//  ERR_LINE      out  1   sticky: a line had pixel count != H_ACTIVE
//  ERR_FRAME     out  1   sticky: a frame had line count != V_ACTIVE
//  ERR_SYNC      out  1   sticky: DEN=1 while HD=0 or VD=0
//  FRAME_SUM     out  16  frame checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in S_UNLOCK; counters 0.
//  - Stage 1 registers HD,VD,DEN,RGB; edges are detected on stage-1 vs previous.
//  - Stage 2 drives PIX_*: PIX_VALID=1 exactly 2 CLK after a cycle with DEN=1
//    (and HD=VD=1); PIX_X/PIX_Y/PIX_RGB hold last value when PIX_VALID=0.
//  - FSM: S_UNLOCK: wait VD fall -> S_VSYNC (partial frame ignored, no checks).
//    S_VSYNC: on VD rise -> S_VBLANK, line cnt=0.
//    S_VBLANK/S_ACTIVE: DEN rise -> x=0; each DEN=1 cycle x++ (saturates at
//    2^XW-1). DEN fall -> line end: ERR_LINE set if x!=H_ACTIVE; line cnt++
//    (saturates at 2^YW-1). VD fall -> frame end -> S_VSYNC.
//  - Frame end: LINES_LAST<=line cnt; FRAME_CNT++; FRAME_DONE=1 one cycle;
//    ERR_FRAME set if line cnt!=V_ACTIVE; LOCKED<=1 only if this frame had no
//    line, frame or sync error, else LOCKED<=0. Zero-line frame -> error.
//  - DEN=1 with HD=0 or VD=0: ERR_SYNC set, pixel not emitted, x not advanced.
//  - VD fall while DEN=1: the open line is closed (checked) first, same cycle.
//  - CLR_ERR and a new error in the same cycle: set wins.
//  - Async reset mid-frame: return to S_UNLOCK, LOCKED=0, FRAME_CNT=0.
// CONFIGURATION
//  LCD_RX_CHECKSUM_EN defined: running 16-bit sum of (R+G+B) over emitted
//   pixels, mod 2^16; latched into FRAME_SUM on FRAME_DONE, running sum cleared
//   at VD rise. Not defined: FRAME_SUM tied to 16'h0000, no adder logic.
// TESTING (small geometry H_ACTIVE=8, V_ACTIVE=4 unless noted)
//  1 Reset then 3 clean frames of 4 lines x 8 px -> FRAME_DONE x3 (1st frame
//    after lock-in is unchecked), LINES_LAST=4, LOCKED=1, all ERR_*=0.
//  2 Pixel RGB=24'h010203 at x=5,y=2 -> PIX_VALID 2 CLK later with PIX_X=5,
//    PIX_Y=2, PIX_RGB=24'h010203.
//  3 One line with 7 px -> ERR_LINE=1 sticky, LOCKED=0 at frame end; next
//    clean frame -> LOCKED=1, ERR_LINE still 1 until CLR_ERR pulse.
//  4 Frame with 5 lines -> ERR_FRAME=1, LINES_LAST=5; DEN=1 during HD=0 ->
//    ERR_SYNC=1 and no PIX_VALID for that cycle.
//  5 RST_n low mid-line -> all outputs 0 asynchronously; next full frame
//    unchecked, following frame LOCKED=1.
//  6 LCD_RX_CHECKSUM_EN, all pixels RGB=24'h010101 -> FRAME_SUM=32*3=16'h0060;
//    full CARACTERES_LCD (800x480) connected -> LOCKED=1, no errors.

Source files
------------

// File: rtl/lcd_video_rx.sv
// Receive side of the HD/VD/DEN/RGB LCD timing interface: recovers pixel coordinates and checks frame geometry.
// Optional macro LCD_RX_CHECKSUM_EN enables the per-frame (R+G+B) checksum on FRAME_SUM.
module lcd_video_rx #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          HD,
    input  logic          VD,
    input  logic          DEN,
    input  logic [7:0]    R,
    input  logic [7:0]    G,
    input  logic [7:0]    B,
    input  logic          CLR_ERR,
    output logic          PIX_VALID,
    output logic [XW-1:0] PIX_X,
    output logic [YW-1:0] PIX_Y,
    output logic [23:0]   PIX_RGB,
    output logic          FRAME_DONE,
    output logic [YW-1:0] LINES_LAST,
    output logic [15:0]   FRAME_CNT,
    output logic          LOCKED,
    output logic          ERR_LINE,
    output logic          ERR_FRAME,
    output logic          ERR_SYNC,
    output logic [15:0]   FRAME_SUM
);

    localparam logic [XW-1:0] H_EXP = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_EXP = YW'(V_ACTIVE);

    typedef enum logic [1:0] {
        S_UNLOCK,
        S_VSYNC,
        S_VBLANK,
        S_ACTIVE
    } state_t;

    state_t state, state_nx;

    logic          hd_s1, vd_s1, den_s1;
    logic [23:0]   rgb_s1;
    logic          vd_s1_q, den_s1_q;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          line_open;
    logic          frame_err_acc;

    logic          good_pix, sync_bad;
    logic          den_rise, den_fall, vd_rise, vd_fall;
    logic          line_end, line_bad;
    logic [XW-1:0] x_cur, x_next;
    logic [YW-1:0] y_eff;
    logic          checking, armed, frame_end;
    logic          set_line, set_sync, set_frame;

    // Stage 1: sync inputs idle high after reset so release does not fake an edge
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            hd_s1    <= 1'b1;
            vd_s1    <= 1'b1;
            den_s1   <= 1'b0;
            rgb_s1   <= '0;
            vd_s1_q  <= 1'b1;
            den_s1_q <= 1'b0;
        end else begin
            hd_s1    <= HD;
            vd_s1    <= VD;
            den_s1   <= DEN;
            rgb_s1   <= {R, G, B};
            vd_s1_q  <= vd_s1;
            den_s1_q <= den_s1;
        end
    end

    assign good_pix = den_s1 & hd_s1 & vd_s1;
    assign sync_bad = den_s1 & ~(hd_s1 & vd_s1);
    assign den_rise = den_s1 & ~den_s1_q;
    assign den_fall = ~den_s1 & den_s1_q;
    assign vd_rise  = vd_s1 & ~vd_s1_q;
    assign vd_fall  = ~vd_s1 & vd_s1_q;

    // A line still open when VD falls is closed in that same cycle
    assign line_end = line_open & (den_fall | (vd_fall & den_s1));
    assign line_bad = line_end & (x_cnt != H_EXP);

    assign x_cur  = den_rise ? '0 : x_cnt;
    assign x_next = (good_pix && x_cur != '1) ? x_cur + XW'(1) : x_cur;
    assign y_eff  = (line_end && y_cnt != '1) ? y_cnt + YW'(1) : y_cnt;

    always_comb begin
        state_nx = state;
        checking = 1'b0;
        armed    = 1'b1;
        case (state)
            S_UNLOCK: begin
                armed = 1'b0;
                if (vd_fall) state_nx = S_VSYNC;
            end
            S_VSYNC: begin
                if (vd_rise) state_nx = S_VBLANK;
            end
            S_VBLANK: begin
                checking = 1'b1;
                if (vd_fall)       state_nx = S_VSYNC;
                else if (den_rise) state_nx = S_ACTIVE;
            end
            S_ACTIVE: begin
                checking = 1'b1;
                if (vd_fall) state_nx = S_VSYNC;
            end
            default: begin
                armed    = 1'b0;
                state_nx = S_UNLOCK;
            end
        endcase
    end

    assign frame_end = checking & vd_fall;
    assign set_line  = checking & line_bad;
    assign set_sync  = armed & sync_bad;
    assign set_frame = frame_end & (y_eff != V_EXP);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= S_UNLOCK;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            line_open <= 1'b0;
        end else begin
            x_cnt <= x_next;
            y_cnt <= vd_rise ? '0 : y_eff;
            if (line_end)      line_open <= 1'b0;
            else if (den_rise) line_open <= 1'b1;
        end
    end

    // Stage 2: pixel strobe and coordinates, held while no pixel is emitted
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            PIX_VALID <= 1'b0;
            PIX_X     <= '0;
            PIX_Y     <= '0;
            PIX_RGB   <= '0;
        end else begin
            PIX_VALID <= good_pix;
            if (good_pix) begin
                PIX_X   <= x_cur;
                PIX_Y   <= y_cnt;
                PIX_RGB <= rgb_s1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            FRAME_DONE    <= 1'b0;
            LINES_LAST    <= '0;
            FRAME_CNT     <= '0;
            LOCKED        <= 1'b0;
            frame_err_acc <= 1'b0;
        end else begin
            FRAME_DONE <= frame_end;
            if (frame_end) begin
                LINES_LAST    <= y_eff;
                FRAME_CNT     <= FRAME_CNT + 16'd1;
                LOCKED        <= ~(frame_err_acc | set_line | set_sync | set_frame);
                frame_err_acc <= 1'b0;
            end else begin
                frame_err_acc <= frame_err_acc | set_line | set_sync;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ERR_LINE  <= 1'b0;
            ERR_FRAME <= 1'b0;
            ERR_SYNC  <= 1'b0;
        end else begin
            ERR_LINE  <= (ERR_LINE  & ~CLR_ERR) | set_line;
            ERR_FRAME <= (ERR_FRAME & ~CLR_ERR) | set_frame;
            ERR_SYNC  <= (ERR_SYNC  & ~CLR_ERR) | set_sync;
        end
    end

`ifdef LCD_RX_CHECKSUM_EN
    logic [15:0] sum_run;
    logic [15:0] px_sum;

    assign px_sum = good_pix ? (16'(rgb_s1[23:16]) + 16'(rgb_s1[15:8]) + 16'(rgb_s1[7:0])) : '0;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sum_run   <= '0;
            FRAME_SUM <= '0;
        end else begin
            sum_run <= vd_rise ? px_sum : sum_run + px_sum;
            if (frame_end) FRAME_SUM <= sum_run;
        end
    end
`else
    assign FRAME_SUM = '0;
`endif

endmodule
